// File: rtl/axis_fifo_pkt.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// axis_fifo_pkt
// Synchronous first-word-fall-through AXI4-Stream FIFO carrying TDATA, TKEEP
// and TLAST. It has an optional store-and-forward packet mode, a fill-level
// output and programmable full/empty threshold flags.
//
// Ports
//   clk, rst_n        single clock, asynchronous active-low reset
//   S_AXIS_*          slave (write) stream: TDATA, TKEEP, TLAST, TVALID, TREADY
//   M_AXIS_*          master (read) stream: TDATA, TKEEP, TLAST, TVALID, TREADY
//   fill_level        number of words currently stored
//   prog_full         fill_level >= PROG_FULL_THRESH
//   prog_empty        fill_level <= PROG_EMPTY_THRESH
// ---------------------------------------------------------------------------
module axis_fifo_pkt #(
    parameter int TDATA_WIDTH       = 512,
    parameter int FIFO_DEPTH        = 512,
    parameter int PACKET_MODE       = 0,
    parameter int PROG_FULL_THRESH  = FIFO_DEPTH - 8,
    parameter int PROG_EMPTY_THRESH = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [TDATA_WIDTH-1:0]            S_AXIS_TDATA,
    input  logic [TDATA_WIDTH/8-1:0]          S_AXIS_TKEEP,
    input  logic                              S_AXIS_TLAST,
    input  logic                              S_AXIS_TVALID,
    output logic                              S_AXIS_TREADY,
    output logic [TDATA_WIDTH-1:0]            M_AXIS_TDATA,
    output logic [TDATA_WIDTH/8-1:0]          M_AXIS_TKEEP,
    output logic                              M_AXIS_TLAST,
    output logic                              M_AXIS_TVALID,
    input  logic                              M_AXIS_TREADY,
    output logic [$clog2(FIFO_DEPTH):0]       fill_level,
    output logic                              prog_full,
    output logic                              prog_empty
);

    localparam int KW = TDATA_WIDTH / 8;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = TDATA_WIDTH + KW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] PF_C    = CW'(PROG_FULL_THRESH);
    localparam logic [CW-1:0] PE_C    = CW'(PROG_EMPTY_THRESH);

    // Entry layout: {tlast, tkeep, tdata}
    logic [EW-1:0]  mem_r [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic [CW-1:0]  pkt_cnt_r;
    logic           release_r;
    logic           s_tready_r;
    logic           m_tvalid_r;
    logic           prog_full_r;
    logic           prog_empty_r;

    logic [EW-1:0]  rd_word_s;
    logic           push_s;
    logic           pop_s;
    logic           push_last_s;
    logic           pop_last_s;
    logic [CW-1:0]  count_nxt_s;
    logic [CW-1:0]  pkt_cnt_nxt_s;
    logic           release_nxt_s;
    logic           m_tvalid_nxt_s;

    assign rd_word_s   = mem_r[rd_ptr_r];
    assign push_s      = S_AXIS_TVALID & s_tready_r;
    assign pop_s       = m_tvalid_r & M_AXIS_TREADY;
    assign push_last_s = push_s & S_AXIS_TLAST;
    assign pop_last_s  = pop_s & rd_word_s[EW-1];

    assign M_AXIS_TDATA  = rd_word_s[TDATA_WIDTH-1:0];
    assign M_AXIS_TKEEP  = rd_word_s[EW-2:TDATA_WIDTH];
    assign M_AXIS_TLAST  = rd_word_s[EW-1];
    assign M_AXIS_TVALID = m_tvalid_r;
    assign S_AXIS_TREADY = s_tready_r;
    assign fill_level    = count_r;
    assign prog_full     = prog_full_r;
    assign prog_empty    = prog_empty_r;

    // Next-state occupancy, packet count, oversize release and output valid
    always_comb begin
        count_nxt_s    = count_r;
        pkt_cnt_nxt_s  = pkt_cnt_r;
        release_nxt_s  = release_r;
        m_tvalid_nxt_s = 1'b0;

        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase

        case ({push_last_s, pop_last_s})
            2'b10:   pkt_cnt_nxt_s = pkt_cnt_r + CW'(1);
            2'b01:   pkt_cnt_nxt_s = pkt_cnt_r - CW'(1);
            default: pkt_cnt_nxt_s = pkt_cnt_r;
        endcase

        // A full FIFO holding no complete packet can never finish one, so the
        // partial packet is let out; the gate closes again at its TLAST.
        if (pop_last_s) begin
            release_nxt_s = 1'b0;
        end else if ((count_nxt_s == DEPTH_C) && (pkt_cnt_nxt_s == {CW{1'b0}})) begin
            release_nxt_s = 1'b1;
        end else begin
            release_nxt_s = release_r;
        end

        if (PACKET_MODE != 0) begin
            m_tvalid_nxt_s = (count_nxt_s != {CW{1'b0}}) &&
                             ((pkt_cnt_nxt_s != {CW{1'b0}}) || release_nxt_s);
        end else begin
            m_tvalid_nxt_s = (count_nxt_s != {CW{1'b0}});
        end
    end

    // Pointers, counters and registered handshake/flag outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            count_r      <= {CW{1'b0}};
            pkt_cnt_r    <= {CW{1'b0}};
            release_r    <= 1'b0;
            s_tready_r   <= 1'b0;
            m_tvalid_r   <= 1'b0;
            prog_full_r  <= 1'b0;
            prog_empty_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r      <= count_nxt_s;
            pkt_cnt_r    <= pkt_cnt_nxt_s;
            release_r    <= release_nxt_s;
            s_tready_r   <= (count_nxt_s < DEPTH_C);
            m_tvalid_r   <= m_tvalid_nxt_s;
            prog_full_r  <= (count_nxt_s >= PF_C);
            prog_empty_r <= (count_nxt_s <= PE_C);
        end
    end

    // Storage array write; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {S_AXIS_TLAST, S_AXIS_TKEEP, S_AXIS_TDATA};
        end
    end

endmodule
